// File: rtl/div_unit.sv
// Radix-2 restoring divider for the EX stage: DIV/DIVU, quotient to LO, remainder to HI.
// One quotient bit per cycle. busy stalls the pipeline and cancel aborts on a flush.
module div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_en,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           r_state;
    logic             r_busy;
    logic             r_done;
    logic             r_dbz;
    logic [WIDTH-1:0] r_quo_out;
    logic [WIDTH-1:0] r_rem_out;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvs_mag;
    logic [CNT_W-1:0] r_cnt;
    logic             r_neg_q;
    logic             r_neg_r;

    logic             w_dvd_neg;
    logic             w_dvs_neg;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic             w_div_zero;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH-1:0] w_trial;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;
    logic [WIDTH-1:0] w_quo_fix;
    logic [WIDTH-1:0] w_rem_fix;

    // Magnitudes stay WIDTH bits wide: -2^(WIDTH-1) negates to itself, read as unsigned.
    assign w_dvd_neg  = signed_en & dividend[WIDTH-1];
    assign w_dvs_neg  = signed_en & divisor[WIDTH-1];
    assign w_dvd_mag  = w_dvd_neg ? -dividend : dividend;
    assign w_dvs_mag  = w_dvs_neg ? -divisor : divisor;
    assign w_div_zero = (divisor == '0);

    // The partial remainder is always below the divisor, so the shifted value fits WIDTH+1 bits
    // and a successful trial difference fits back into WIDTH bits.
    assign w_shift   = {r_rem, r_quo[WIDTH-1]};
    assign w_ge      = (w_shift >= {1'b0, r_dvs_mag});
    assign w_trial   = w_shift[WIDTH-1:0] - r_dvs_mag;
    assign w_rem_nxt = w_ge ? w_trial : w_shift[WIDTH-1:0];
    assign w_quo_nxt = {r_quo[WIDTH-2:0], w_ge};
    assign w_quo_fix = r_neg_q ? -w_quo_nxt : w_quo_nxt;
    assign w_rem_fix = r_neg_r ? -w_rem_nxt : w_rem_nxt;

    // NOTE: every register in this block uses <= so each branch reads pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_dbz     <= 1'b0;
            r_quo_out <= '0;
            r_rem_out <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_dvs_mag <= '0;
            r_cnt     <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
        end else if (cancel) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    if (start) begin
                        if (w_div_zero) begin
                            r_state   <= DONE;
                            r_done    <= 1'b1;
                            r_quo_out <= '1;
                            r_rem_out <= dividend;
                            r_dbz     <= 1'b1;
                        end else begin
                            r_state   <= RUN;
                            r_busy    <= 1'b1;
                            r_rem     <= '0;
                            r_quo     <= w_dvd_mag;
                            r_dvs_mag <= w_dvs_mag;
                            r_cnt     <= '0;
                            r_neg_q   <= w_dvd_neg ^ w_dvs_neg;
                            r_neg_r   <= w_dvd_neg;
                        end
                    end
                end
                RUN: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        r_state   <= DONE;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_quo_out <= w_quo_fix;
                        r_rem_out <= w_rem_fix;
                        r_dbz     <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign quotient    = r_quo_out;
    assign remainder   = r_rem_out;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: a WIDTH=32 instance and a WIDTH=8 instance sharing clk and rst.
// Expected values are hand-computed constants.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, signed_en, cancel;
    logic [31:0] dividend, divisor;
    logic        busy, done, div_by_zero;
    logic [31:0] quotient, remainder;

    logic        start8, signed8, cancel8;
    logic [7:0]  dvd8, dvs8;
    logic        busy8, done8, dbz8;
    logic [7:0]  quo8, rem8;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    div_unit #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(start), .signed_en(signed_en),
        .dividend(dividend), .divisor(divisor), .cancel(cancel),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    div_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .signed_en(signed8),
        .dividend(dvd8), .divisor(dvs8), .cancel(cancel8),
        .busy(busy8), .done(done8), .quotient(quo8), .remainder(rem8),
        .div_by_zero(dbz8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launches one divide and returns edges-to-done (0 on timeout), busy cycles, and busy in the done cycle.
    // When inj > 0 a 50/5 start is pulsed during RUN; it must be ignored.
    task automatic do_op32(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           input int inj, output int lat, output int nbusy, output logic busy_dn);
        signed_en = sgn;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        lat       = 0;
        nbusy     = 0;
        busy_dn   = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            tick();
            start = 1'b0;
            if (done) begin
                lat     = i;
                busy_dn = busy;
                break;
            end
            if (busy) nbusy++;
            if (i == inj) begin
                start     = 1'b1;
                signed_en = 1'b0;
                dividend  = 32'd50;
                divisor   = 32'd5;
            end
        end
    endtask

    task automatic do_op8(input logic sgn, input logic [7:0] a, input logic [7:0] b,
                          output int lat);
        signed8 = sgn;
        dvd8    = a;
        dvs8    = b;
        start8  = 1'b1;
        lat     = 0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            start8 = 1'b0;
            if (done8) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        int   lat, nbusy, ndone;
        logic bdn;

        rst = 1'b1; start = 1'b0; signed_en = 1'b0; cancel = 1'b0;
        dividend = '0; divisor = '0;
        start8 = 1'b0; signed8 = 1'b0; cancel8 = 1'b0; dvd8 = '0; dvs8 = '0;
        tick();
        tick();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_quo", quotient, 32'd0);
        check("rst_rem", remainder, 32'd0);
        check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        rst = 1'b0;
        tick();

        // Unsigned 100 / 7
        do_op32(1'b0, 32'd100, 32'd7, 0, lat, nbusy, bdn);
        check("u100_7_lat", lat, 33);
        check("u100_7_busy_cycles", nbusy, 32);
        check("u100_7_busy_at_done", {31'd0, bdn}, 32'd0);
        check("u100_7_quo", quotient, 32'd14);
        check("u100_7_rem", remainder, 32'd2);
        check("u100_7_dbz", {31'd0, div_by_zero}, 32'd0);
        tick();
        check("done_one_cycle", {31'd0, done}, 32'd0);
        check("idle_busy", {31'd0, busy}, 32'd0);

        // Unsigned with dividend MSB set must not be treated as negative
        do_op32(1'b0, 32'hFFFF_FFFF, 32'h10, 0, lat, nbusy, bdn);
        check("u_big_quo", quotient, 32'h0FFF_FFFF);
        check("u_big_rem", remainder, 32'hF);

        // Signed cases
        do_op32(1'b1, 32'hFFFF_FFF9, 32'h2, 0, lat, nbusy, bdn);
        check("s_m7_2_quo", quotient, 32'hFFFF_FFFD);
        check("s_m7_2_rem", remainder, 32'hFFFF_FFFF);
        do_op32(1'b1, 32'h7, 32'hFFFF_FFFE, 0, lat, nbusy, bdn);
        check("s_7_m2_quo", quotient, 32'hFFFF_FFFD);
        check("s_7_m2_rem", remainder, 32'h1);
        do_op32(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, lat, nbusy, bdn);
        check("s_ovf_lat", lat, 33);
        check("s_ovf_quo", quotient, 32'h8000_0000);
        check("s_ovf_rem", remainder, 32'h0);
        check("s_ovf_dbz", {31'd0, div_by_zero}, 32'd0);
        tick();

        // Divide by zero
        do_op32(1'b0, 32'h1234, 32'h0, 0, lat, nbusy, bdn);
        check("dz_lat", lat, 1);
        check("dz_busy_cycles", nbusy, 0);
        check("dz_busy_at_done", {31'd0, bdn}, 32'd0);
        check("dz_quo", quotient, 32'hFFFF_FFFF);
        check("dz_rem", remainder, 32'h1234);
        check("dz_dbz", {31'd0, div_by_zero}, 32'd1);
        tick();

        // Cancel on RUN cycle 10
        signed_en = 1'b0; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        check("cancel_pre_busy", {31'd0, busy}, 32'd1);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("cancel_busy", {31'd0, busy}, 32'd0);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) ndone++;
            tick();
        end
        check("cancel_no_done", ndone, 0);
        check("cancel_quo_held", quotient, 32'hFFFF_FFFF);
        check("cancel_rem_held", remainder, 32'h1234);
        check("cancel_dbz_held", {31'd0, div_by_zero}, 32'd1);
        do_op32(1'b0, 32'd9, 32'd3, 0, lat, nbusy, bdn);
        check("after_cancel_quo", quotient, 32'd3);
        check("after_cancel_rem", remainder, 32'd0);
        tick();

        // Start pulsed during RUN is ignored
        do_op32(1'b0, 32'd20, 32'd3, 5, lat, nbusy, bdn);
        check("ign_lat", lat, 33);
        check("ign_quo", quotient, 32'd6);
        check("ign_rem", remainder, 32'd2);

        // Back-to-back: start issued in the DONE cycle
        do_op32(1'b0, 32'd50, 32'd5, 0, lat, nbusy, bdn);
        check("b2b_lat", lat, 33);
        check("b2b_quo", quotient, 32'd10);
        check("b2b_rem", remainder, 32'd0);
        tick();

        // Reset mid-RUN
        signed_en = 1'b0; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_quo", quotient, 32'd0);
        check("midrst_rem", remainder, 32'd0);
        check("midrst_dbz", {31'd0, div_by_zero}, 32'd0);
        rst = 1'b0;
        repeat (3) tick();
        check("midrst_idle", {31'd0, busy | done}, 32'd0);

        // WIDTH=8 instance
        do_op8(1'b0, 8'd200, 8'd9, lat);
        check("w8_u_lat", lat, 9);
        check("w8_u_quo", {24'd0, quo8}, 32'd22);
        check("w8_u_rem", {24'd0, rem8}, 32'd2);
        tick();
        do_op8(1'b1, 8'h80, 8'hFF, lat);
        check("w8_ovf_quo", {24'd0, quo8}, 32'h80);
        check("w8_ovf_rem", {24'd0, rem8}, 32'h0);
        check("w8_ovf_dbz", {31'd0, dbz8}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
